obstacle_scheduler: RTL
=======================

Name: obstacle_scheduler

Overview:
Sequences the obstacle down counter for the dino game. Each cycle of its loop it:
- loads the counter with a pseudo-random gap code;
- waits for the count to reach zero;
- emits a one-cycle spawn pulse with a random obstacle type.

It also raises a speed level as spawns accumulate, which shortens the gaps. It sits between the game-control logic and the down counter, and drives the counter's load_en and load_value directly.

Parameters:
SPAWNS_PER_LEVEL, 8, spawns needed per speed_level increment (range 1..255).
HARD_LEVEL, 4, speed_level at or above which gap codes are halved.
LFSR_SEED, 8'hA5, LFSR value after reset (must be nonzero).

Ports:
clock  input  1  system clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
game_run  input  1  level; high while a game is in progress.
game_over  input  1  level/pulse; collision detected.
count_in  input  9  current value of the down counter.
load_en  output  1  one-cycle load strobe to the down counter.
load_value  output  2  gap code presented with load_en.
spawn  output  1  one-cycle pulse; spawn an obstacle.
obstacle_type  output  2  type of the obstacle; valid while spawn=1, held otherwise.
speed_level  output  3  current difficulty, saturating at 7.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE, lfsr=LFSR_SEED, spawn_cnt=0.
  - Outputs: load_en=0, load_value=0, spawn=0, obstacle_type=0, speed_level=0.
  - Reset asserted in any state wins over all other inputs in that cycle.
- LFSR:
  - 8-bit, advances every non-reset cycle.
  - Update: next={lfsr[6:0],fb}, with fb=lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3].
- Gap code:
  - gc = lfsr[1:0] when speed_level<HARD_LEVEL.
  - gc = {1'b0,lfsr[1]} when speed_level>=HARD_LEVEL.
- States: IDLE, LOAD, ARM, WAIT, SPAWN, HALT. All outputs are registered.
- IDLE:
  - Outputs are 0, except speed_level and obstacle_type, which hold.
  - game_run=1 and game_over=0 -> LOAD, with speed_level=0 and spawn_cnt=0.
- LOAD:
  - load_en=1 and load_value=gc for exactly one cycle.
  - -> ARM.
- ARM:
  - One dead cycle so the counter captures the load; count_in is ignored.
  - load_en=0. -> WAIT.
- WAIT:
  - count_in==9'd0 -> SPAWN.
  - Any other value stays in WAIT; there is no timeout.
- SPAWN:
  - spawn=1 for one cycle, with obstacle_type=lfsr[3:2] sampled on entry.
  - spawn_cnt++. When spawn_cnt reaches SPAWNS_PER_LEVEL-1: spawn_cnt wraps to 0 and speed_level increments, saturating at 7.
  - -> LOAD, so the next load_en occurs 1 cycle after spawn.
- Abort and halt priority:
  - game_over=1 in LOAD/ARM/WAIT/SPAWN -> HALT next cycle.
  - A spawn or load pending in that cycle is suppressed: load_en=0, spawn=0.
  - game_over beats count_in==0 in the same cycle.
- Run drop:
  - game_run=0 in LOAD/ARM/WAIT/SPAWN with game_over=0 -> IDLE.
  - No further load or spawn is issued.
- HALT:
  - load_en=0 and spawn=0. speed_level and obstacle_type freeze, for score display.
  - game_run=0 -> IDLE. game_over alone never exits HALT.
- Minimum loop: LOAD->ARM->WAIT->SPAWN->LOAD is 4 cycles when count_in is already 0 in WAIT.
- load_value holds its last value when load_en=0.

Decomposition:
- Package dino_pkg:
  - state enum sched_state_t;
  - widths COUNT_W=9, GAP_W=2, TYPE_W=2, LEVEL_W=3;
  - LFSR tap constant 8'b1011_1000;
  - MAX_LEVEL=7.
- Sub-module obstacle_lfsr:
  - ports clock, reset, seed param, value[7:0];
  - shared later by the cloud and sky blocks.
- The FSM, gap mapping and level counter stay in obstacle_scheduler.

Test Plan:
- Reset, then hold game_run=0 for 10 cycles -> all outputs 0, state IDLE, lfsr 8'hA5 then 8'h4A one cycle after reset release.
- game_run=1, with the bench counter model counting down from 5 after load -> load_en pulses 1 cycle after start, spawn pulses exactly when count_in==0 is seen in WAIT, next load_en 1 cycle after spawn.
- Run 8 spawns with SPAWNS_PER_LEVEL=8 -> speed_level 0->1 on the 8th spawn. Run 64 more spawns -> speed_level saturates at 7. With speed_level>=4, load_value is never 2'b10 or 2'b11.
- Assert game_over in the same cycle count_in==0 in WAIT -> no spawn, HALT, speed_level frozen. Drop game_run -> IDLE. Raise it again -> speed_level resets to 0.
- Drop game_run mid-WAIT -> IDLE next cycle, no load_en or spawn afterwards. Assert reset mid-SPAWN -> all outputs 0 next cycle.
- Hold count_in at 0 continuously -> steady 4-cycle loop with one load_en and one spawn per loop. obstacle_type matches lfsr[3:2] of the bench reference model.

Source files
------------

// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg
// Shared types and constants for the dino game obstacle logic.
//   sched_state_t : obstacle scheduler FSM states
//   COUNT_W       : width of the obstacle down counter value
//   GAP_W         : width of the gap code loaded into the down counter
//   TYPE_W        : width of the obstacle type code
//   LEVEL_W       : width of the speed level
//   LFSR_TAPS     : feedback taps of the 8-bit obstacle LFSR (bits 7,5,4,3)
//   MAX_LEVEL     : saturation value of the speed level
// -----------------------------------------------------------------------------
package dino_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      ARM   = 3'd2,
      WAIT  = 3'd3,
      SPAWN = 3'd4,
      HALT  = 3'd5
   } sched_state_t;

   localparam int COUNT_W = 9;
   localparam int GAP_W   = 2;
   localparam int TYPE_W  = 2;
   localparam int LEVEL_W = 3;

   localparam logic [7:0]         LFSR_TAPS = 8'b1011_1000;
   localparam logic [LEVEL_W-1:0] MAX_LEVEL = 3'd7;

endpackage

// File: rtl/obstacle_lfsr.sv
// -----------------------------------------------------------------------------
// obstacle_lfsr
// Free-running 8-bit Fibonacci LFSR, shifting left with the feedback bit
// entering at bit 0. Steps on every clock edge that is not a reset edge.
//   clock : system clock
//   reset : synchronous, active-high; loads SEED
//   value : current LFSR state
// -----------------------------------------------------------------------------
module obstacle_lfsr
   import dino_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   output logic [7:0] value
);

   always_ff @(posedge clock) begin
      if (reset) begin
         value <= SEED;
      end else begin
         value <= {value[6:0], ^(value & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/obstacle_scheduler.sv
// -----------------------------------------------------------------------------
// obstacle_scheduler
// Drives the obstacle down counter: loads a pseudo-random gap code, waits for
// the count to reach zero, then pulses spawn with a random obstacle type.
// A speed level climbs as spawns accumulate and shortens the gaps once it
// reaches HARD_LEVEL.
//   clock         : system clock
//   reset         : synchronous, active-high reset
//   game_run      : high while a game is in progress
//   game_over     : collision detected; stops the sequence until game_run drops
//   count_in      : current value of the down counter
//   load_en       : one-cycle load strobe to the down counter
//   load_value    : gap code presented with load_en (held otherwise)
//   spawn         : one-cycle obstacle spawn pulse
//   obstacle_type : obstacle type, valid with spawn, held otherwise
//   speed_level   : current difficulty, saturating at MAX_LEVEL
// All outputs are registered.
// -----------------------------------------------------------------------------
module obstacle_scheduler
   import dino_pkg::*;
#(
   parameter int         SPAWNS_PER_LEVEL = 8,
   parameter int         HARD_LEVEL       = 4,
   parameter logic [7:0] LFSR_SEED        = 8'hA5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               game_run,
   input  logic               game_over,
   input  logic [COUNT_W-1:0] count_in,
   output logic               load_en,
   output logic [GAP_W-1:0]   load_value,
   output logic               spawn,
   output logic [TYPE_W-1:0]  obstacle_type,
   output logic [LEVEL_W-1:0] speed_level
);

   localparam logic [LEVEL_W-1:0] HARD_LVL  = LEVEL_W'(HARD_LEVEL);
   localparam logic [7:0]         SPAWN_LAST = 8'(SPAWNS_PER_LEVEL - 1);

   sched_state_t       state, state_next;
   logic [7:0]         spawn_cnt, spawn_cnt_next;
   logic [LEVEL_W-1:0] level_next;
   logic               load_en_next, spawn_next;
   logic [GAP_W-1:0]   load_value_next;
   logic [TYPE_W-1:0]  type_next;
   logic [7:0]         lfsr;
   logic [3:0]         lfsr_hi_unused;

   // Only the low nibble feeds this block; the upper bits are for the
   // other consumers of the shared LFSR.
   assign lfsr_hi_unused = lfsr[7:4];

   obstacle_lfsr #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clock (clock),
      .reset (reset),
      .value (lfsr)
   );

   // Harder levels drop the top gap bit, so only the two shortest gaps remain.
   function automatic logic [GAP_W-1:0] gap_code(input logic [1:0]         lf,
                                                 input logic [LEVEL_W-1:0] lvl);
      if (lvl >= HARD_LVL) begin
         return {1'b0, lf[1]};
      end
      return lf;
   endfunction

   always_comb begin
      state_next      = state;
      spawn_cnt_next  = spawn_cnt;
      level_next      = speed_level;
      load_value_next = load_value;
      type_next       = obstacle_type;

      unique case (state)
         IDLE: begin
            if (game_run && !game_over) begin
               state_next = LOAD;
            end
         end
         LOAD, ARM, WAIT, SPAWN: begin
            // game_over outranks both a run drop and a zero count.
            if (game_over) begin
               state_next = HALT;
            end else if (!game_run) begin
               state_next = IDLE;
            end else begin
               unique case (state)
                  LOAD:    state_next = ARM;
                  ARM:     state_next = WAIT;
                  WAIT:    state_next = (count_in == '0) ? SPAWN : WAIT;
                  default: state_next = LOAD;
               endcase
            end
         end
         HALT: begin
            if (!game_run) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      // A new game restarts the difficulty ramp.
      if (state == IDLE && state_next == LOAD) begin
         spawn_cnt_next = '0;
         level_next     = '0;
      end

      if (state_next == SPAWN) begin
         type_next = lfsr[3:2];
         if (spawn_cnt == SPAWN_LAST) begin
            spawn_cnt_next = '0;
            if (speed_level != MAX_LEVEL) begin
               level_next = speed_level + 3'd1;
            end
         end else begin
            spawn_cnt_next = spawn_cnt + 8'd1;
         end
      end

      // Gap follows the level that will be in force alongside load_en.
      if (state_next == LOAD) begin
         load_value_next = gap_code(lfsr[1:0], level_next);
      end else if (state_next == IDLE) begin
         load_value_next = '0;
      end

      load_en_next = (state_next == LOAD);
      spawn_next   = (state_next == SPAWN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         spawn_cnt     <= '0;
         load_en       <= 1'b0;
         load_value    <= '0;
         spawn         <= 1'b0;
         obstacle_type <= '0;
         speed_level   <= '0;
      end else begin
         state         <= state_next;
         spawn_cnt     <= spawn_cnt_next;
         load_en       <= load_en_next;
         load_value    <= load_value_next;
         spawn         <= spawn_next;
         obstacle_type <= type_next;
         speed_level   <= level_next;
      end
   end

endmodule
